// File: rtl/audio_dac_transmitter_if.sv
// Bundles the FIFO read port and codec DAC pins of audio_dac_transmitter.
//   AUD_DAC_CLK   codec LRCK, 1 = left channel, 0 = right channel
//   rdempty_sig   FIFO empty flag
//   q_sig         FIFO read data {left, right}, valid the cycle after rdreq_sig
//   rdreq_sig     FIFO read request, single-cycle pulse
//   AUD_DAC_DATA  serial I2S data to the codec
//   underrun_sig  pulse when a frame starts with no sample available
// slave: transmitter side; master: FIFO/codec side.
interface audio_dac_transmitter_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                      AUD_DAC_CLK;
    logic                      rdempty_sig;
    logic [2*DATA_WIDTH-1:0]   q_sig;
    logic                      rdreq_sig;
    logic                      AUD_DAC_DATA;
    logic                      underrun_sig;

    modport slave (
        input  AUD_DAC_CLK,
        input  rdempty_sig,
        input  q_sig,
        output rdreq_sig,
        output AUD_DAC_DATA,
        output underrun_sig
    );

    modport master (
        output AUD_DAC_CLK,
        output rdempty_sig,
        output q_sig,
        input  rdreq_sig,
        input  AUD_DAC_DATA,
        input  underrun_sig
    );
endinterface

// File: rtl/audio_dac_transmitter.sv
// I2S playback transmitter. Prefetches one stereo word per frame from the DAC FIFO during
// the right half, loads it at the LRCK rising edge and shifts each channel out MSB-first,
// zero-padding the remainder of each half. A frame with no word is muted and flagged.
//   AUD_BCLK  codec bit clock, all logic on its rising edge
//   reset_n   asynchronous active-low reset
//   dac_io    FIFO read port and codec DAC pins (see audio_dac_transmitter_if)
module audio_dac_transmitter #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                    AUD_BCLK,
    input  logic                    reset_n,
    audio_dac_transmitter_if.slave  dac_io
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
    localparam int unsigned WordW = 2 * DATA_WIDTH;

    localparam logic [0:0] StSync = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             lrck_prev_q, lrck_seen_q;
    logic [WordW-1:0] tx_word_q, tx_word_d;
    logic [WordW-1:0] next_word_q, next_word_d;
    logic             next_valid_q, next_valid_d;
    logic             rd_pending_q, rd_pending_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic             dac_data_q, dac_data_d;

    logic                  lrck;
    logic                  rise, fall, run, load;
    logic                  rd_req, underrun;
    logic [DATA_WIDTH-1:0] half_word, half_shift;

    assign lrck = dac_io.AUD_DAC_CLK;
    assign rise = lrck_seen_q & lrck & ~lrck_prev_q;
    assign fall = lrck_seen_q & ~lrck & lrck_prev_q;
    assign run  = (state_q == StRun);
    assign load = run & rise;

    // Prefetch starts on the very fall that leaves StSync, so the first frame can be fed.
    assign rd_req   = (run | fall) & ~lrck & ~next_valid_q & ~rd_pending_q & ~dac_io.rdempty_sig;
    assign underrun = load & ~rd_pending_q & ~next_valid_q;

    always_comb begin
        state_d      = state_q;
        tx_word_d    = tx_word_q;
        next_word_d  = next_word_q;
        next_valid_d = next_valid_q;
        rd_pending_d = rd_pending_q;

        if (state_q == StSync && fall) begin
            state_d = StRun;
        end

        if (load) begin
            if (rd_pending_q) begin
                // Read issued on the last right-half cycle: take the data straight off the bus.
                tx_word_d    = dac_io.q_sig;
                rd_pending_d = 1'b0;
                next_valid_d = 1'b0;
            end else if (next_valid_q) begin
                tx_word_d    = next_word_q;
                next_valid_d = 1'b0;
            end else begin
                tx_word_d = '0;
            end
        end else if (rd_pending_q) begin
            next_word_d  = dac_io.q_sig;
            next_valid_d = 1'b1;
            rd_pending_d = 1'b0;
        end

        if (rd_req) begin
            rd_pending_d = 1'b1;
        end
    end

    // tx_word_d equals tx_word_q except on load, so the MSB comes from the new word on rise.
    assign half_word  = lrck ? tx_word_d[WordW-1:DATA_WIDTH] : tx_word_d[DATA_WIDTH-1:0];
    assign half_shift = half_word << bit_cnt_q;

    always_comb begin
        dac_data_d = 1'b0;
        bit_cnt_d  = bit_cnt_q;
        if (!run) begin
            if (fall) begin
                bit_cnt_d = CntW'(1);
            end
        end else if (rise || fall) begin
            dac_data_d = half_word[DATA_WIDTH-1];
            bit_cnt_d  = CntW'(1);
        end else if (bit_cnt_q < CntW'(DATA_WIDTH)) begin
            dac_data_d = half_shift[DATA_WIDTH-1];
            bit_cnt_d  = bit_cnt_q + CntW'(1);
        end else begin
            bit_cnt_d = CntW'(DATA_WIDTH);
        end
    end

    always_ff @(posedge AUD_BCLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StSync;
            lrck_prev_q  <= 1'b0;
            lrck_seen_q  <= 1'b0;
            tx_word_q    <= '0;
            next_word_q  <= '0;
            next_valid_q <= 1'b0;
            rd_pending_q <= 1'b0;
            bit_cnt_q    <= '0;
            dac_data_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lrck_prev_q  <= lrck;
            lrck_seen_q  <= 1'b1;
            tx_word_q    <= tx_word_d;
            next_word_q  <= next_word_d;
            next_valid_q <= next_valid_d;
            rd_pending_q <= rd_pending_d;
            bit_cnt_q    <= bit_cnt_d;
            dac_data_q   <= dac_data_d;
        end
    end

    assign dac_io.rdreq_sig    = rd_req;
    assign dac_io.underrun_sig = underrun;
    assign dac_io.AUD_DAC_DATA = dac_data_q;

endmodule

// File: tb/tb_audio_dac_transmitter.sv
module tb_audio_dac_transmitter;
    localparam int unsigned DW = 16;

    logic clk;
    logic rst_n;

    audio_dac_transmitter_if #(.DATA_WIDTH(DW)) dac ();

    audio_dac_transmitter #(.DATA_WIDTH(DW)) dut (
        .AUD_BCLK (clk),
        .reset_n  (rst_n),
        .dac_io   (dac)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO environment: normal-mode read, data one cycle after the request.
    logic [31:0] fifo[$];
    always @(posedge clk) begin
        if (dac.rdreq_sig && fifo.size() > 0) begin
            dac.q_sig <= fifo.pop_front();
        end
    end

    // Behavioural model: frame-level view of what the codec must see.
    logic [31:0] mq[$];
    bit          m_seen, m_prev, m_run, m_held;
    logic [31:0] m_word, m_frame;
    int          m_k;
    logic        exp_data, e_rdreq, e_under;
    logic [15:0] m_half;
    bit          changed;
    int          n_rdreq, n_under;

    task automatic model_reset();
        m_seen   = 0;
        m_prev   = 0;
        m_run    = 0;
        m_held   = 0;
        m_word   = '0;
        m_frame  = '0;
        m_k      = 0;
        exp_data = 1'b0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        n_rdreq += int'(dac.rdreq_sig);
        n_under += int'(dac.underrun_sig);
        if (!rst_n) begin
            check("reset_data", 32'(dac.AUD_DAC_DATA), 32'd0);
            check("reset_rdreq", 32'(dac.rdreq_sig), 32'd0);
            check("reset_underrun", 32'(dac.underrun_sig), 32'd0);
            model_reset();
        end else begin
            check("serial_data", 32'(dac.AUD_DAC_DATA), 32'(exp_data));
            changed = m_seen && (dac.AUD_DAC_CLK != m_prev);
            m_k     = changed ? 0 : (m_k < 1000 ? m_k + 1 : m_k);
            e_rdreq = 1'b0;
            e_under = 1'b0;
            if (!m_run && changed && !dac.AUD_DAC_CLK) m_run = 1;
            if (m_run && changed && dac.AUD_DAC_CLK) begin
                e_under = !m_held;
                m_frame = m_held ? m_word : 32'd0;
                m_held  = 0;
            end
            if (m_run && !dac.AUD_DAC_CLK && !m_held && mq.size() > 0) begin
                e_rdreq = 1'b1;
                m_word  = mq.pop_front();
                m_held  = 1;
            end
            m_half   = dac.AUD_DAC_CLK ? m_frame[31:16] : m_frame[15:0];
            exp_data = (m_k < int'(DW)) ? m_half[int'(DW) - 1 - m_k] : 1'b0;
            check("rdreq", 32'(dac.rdreq_sig), 32'(e_rdreq));
            check("underrun", 32'(dac.underrun_sig), 32'(e_under));
            m_prev = dac.AUD_DAC_CLK;
            m_seen = 1;
        end
    end

    logic [31:0] cap;

    task automatic push(input logic [31:0] w);
        fifo.push_back(w);
        mq.push_back(w);
    endtask

    task automatic clr();
        n_rdreq = 0;
        n_under = 0;
    endtask

    // One LRCK half of len BCLKs; cap collects the bits launched during it, oldest first.
    task automatic run_half(input logic level, input int len, input int push_at,
                            input logic [31:0] push_word);
        cap = '0;
        for (int i = 0; i < len; i++) begin
            if (i == push_at) push(push_word);
            dac.AUD_DAC_CLK = level;
            dac.rdempty_sig = (fifo.size() == 0);
            @(posedge clk);
            #1;
            cap = {cap[30:0], dac.AUD_DAC_DATA};
        end
    endtask

    logic [31:0] acc;
    logic [31:0] t6_exp [4];

    initial begin
        t6_exp = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h0000_0000};
        rst_n = 1'b0;
        dac.AUD_DAC_CLK = 1'b1;
        dac.rdempty_sig = 1'b1;
        clr();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // T1: single word, sync on first fall, emitted in the next frame.
        push(32'hA5A5_3C3C);
        run_half(1'b1, 32, -1, '0);
        check("t1_sync_silent", cap, 32'd0);
        clr();
        run_half(1'b0, 32, -1, '0);
        check("t1_rdreq_count", 32'(n_rdreq), 32'd1);
        check("t1_first_right_silent", cap, 32'd0);
        clr();
        run_half(1'b1, 32, -1, '0);
        check("t1_left_bits", cap, 32'hA5A5_0000);
        check("t1_no_underrun", 32'(n_under), 32'd0);
        clr();
        run_half(1'b0, 32, -1, '0);
        check("t1_right_bits", cap, 32'h3C3C_0000);
        check("t1_no_second_read", 32'(n_rdreq), 32'd0);

        // T2: sustained underrun.
        clr();
        acc = '0;
        repeat (4) begin
            run_half(1'b1, 32, -1, '0);
            acc |= cap;
            run_half(1'b0, 32, -1, '0);
            acc |= cap;
        end
        check("t2_underrun_count", 32'(n_under), 32'd4);
        check("t2_rdreq_count", 32'(n_rdreq), 32'd0);
        check("t2_all_zero", acc, 32'd0);

        // T3: word arrives on the last right-half cycle.
        run_half(1'b1, 32, -1, '0);
        clr();
        run_half(1'b0, 32, 31, 32'h8001_7FFE);
        check("t3_rdreq_count", 32'(n_rdreq), 32'd1);
        clr();
        run_half(1'b1, 32, -1, '0);
        check("t3_left_bits", cap, 32'h8001_0000);
        check("t3_no_underrun", 32'(n_under), 32'd0);

        // T4: reset in the middle of a left half loses the prefetched word.
        push(32'h1234_5678);
        push(32'hCAFE_BABE);
        run_half(1'b0, 32, -1, '0);
        check("t3_right_bits", cap, 32'h7FFE_0000);
        clr();
        run_half(1'b1, 5, -1, '0);
        check("t4_pre_reset_bits", cap, 32'h0000_0002);
        rst_n = 1'b0;
        #1;
        check("t4_async_data", 32'(dac.AUD_DAC_DATA), 32'd0);
        check("t4_async_rdreq", 32'(dac.rdreq_sig), 32'd0);
        check("t4_async_underrun", 32'(dac.underrun_sig), 32'd0);
        run_half(1'b1, 3, -1, '0);
        rst_n = 1'b1;
        run_half(1'b1, 24, -1, '0);
        check("t4_post_reset_left", cap, 32'd0);
        clr();
        run_half(1'b0, 32, -1, '0);
        check("t4_silent_right", cap, 32'd0);
        check("t4_rdreq_count", 32'(n_rdreq), 32'd1);
        clr();
        run_half(1'b1, 32, -1, '0);
        check("t4_left_bits", cap, 32'hCAFE_0000);
        check("t4_no_underrun", 32'(n_under), 32'd0);

        // T5: short halves of 8 BCLK.
        push(32'hF0F0_0F0F);
        run_half(1'b0, 32, -1, '0);
        check("t4_right_bits", cap, 32'hBABE_0000);
        run_half(1'b1, 8, -1, '0);
        check("t5_left_bits", cap, 32'h0000_00F0);
        run_half(1'b0, 8, -1, '0);
        check("t5_right_bits", cap, 32'h0000_000F);

        // T6: three queued words then underrun.
        clr();
        run_half(1'b1, 32, -1, '0);
        check("t6_lead_underrun", 32'(n_under), 32'd1);
        clr();
        push(32'h1111_AAAA);
        push(32'h2222_BBBB);
        push(32'h3333_CCCC);
        for (int f = 0; f < 4; f++) begin
            run_half(1'b0, 32, -1, '0);
            run_half(1'b1, 32, -1, '0);
            check("t6_left_bits", cap, t6_exp[f]);
        end
        check("t6_rdreq_count", 32'(n_rdreq), 32'd3);
        check("t6_underrun_count", 32'(n_under), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
